// File: rtl/alu_op_sequencer.sv
// Registered, handshaked ALU micro-op sequencer: turns each accepted opcode into one or two micro-op beats.
// Optional performance counters are built only when ALUSEQ_PERF_EN is defined.
module alu_op_sequencer #(
    parameter int OPC_W = 6,
    parameter int OPW   = 5,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [OPC_W-1:0] Opcode,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [OPW-1:0]   Operation,
    output logic             Step,
    output logic             Last,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] InstrCnt,
    output logic [CNT_W-1:0] StallCnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S0   = 2'd1,
        S1   = 2'd2
    } state_t;

    // Handshake: a beat transfers on a cycle where OutValid & OutReady; an opcode is
    // taken on InValid & InReady unless Flush is high in that cycle.

    // Result packing: {illegal, last, op[4:0]}.
    function automatic logic [6:0] decode(input logic [OPC_W-1:0] opc, input logic step);
        logic [5:0]       o;
        logic [4:0]       op;
        logic             last;
        logic             ill;
        logic [OPC_W-1:0] hi;
        o    = opc[5:0];
        hi   = opc >> 6;
        op   = 5'b00010;
        last = 1'b1;
        ill  = 1'b0;
        casez (o)
            6'b00000?:          op = 5'b00010;
            6'b010???:          op = {2'b00, o[2:0]};
            6'b11001?, 6'b1101??: op = {2'b00, o[2:0]};
            6'b111001:          op = 5'b01100;
            6'b111010:          op = 5'b01101;
            6'b111011:          op = 5'b01110;
            6'b111100:          op = 5'b10000;
            6'b1000??: begin
                op   = step ? 5'b00010 : {3'b010, o[1:0]};
                last = step;
            end
            6'b111101: begin
                op   = step ? 5'b01111 : 5'b00010;
                last = step;
            end
            6'b111110: begin
                op   = step ? 5'b10001 : 5'b00010;
                last = step;
            end
            6'b000010: begin
                op   = step ? 5'b00010 : 5'b10010;
                last = step;
            end
            default:            ill = 1'b1;
        endcase
        if (hi != '0) begin
            op   = 5'b00010;
            last = 1'b1;
            ill  = 1'b1;
        end
        return {ill, last, op};
    endfunction

    state_t           state_q, state_n;
    logic [OPC_W-1:0] opc_q, opc_n;
    logic             valid_q, valid_n;
    logic [OPW-1:0]   op_q, op_n;
    logic             step_q, step_n;
    logic             last_q, last_n;
    logic             ill_q, ill_n;
    logic             ready_en_q;
    logic             accept;
    logic             hs;
    logic [6:0]       dec_in;
    logic [6:0]       dec_s1;

    assign dec_in  = decode(Opcode, 1'b0);
    assign dec_s1  = decode(opc_q, 1'b1);
    assign hs      = valid_q & OutReady;
    // ready_en_q keeps InReady low until the first clock after reset release.
    assign InReady = ready_en_q & ((state_q == IDLE) | (hs & last_q) | Flush);
    assign accept  = InValid & InReady & ~Flush;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            opc_q      <= '0;
            valid_q    <= 1'b0;
            op_q       <= '0;
            step_q     <= 1'b0;
            last_q     <= 1'b0;
            ill_q      <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            opc_q      <= opc_n;
            valid_q    <= valid_n;
            op_q       <= op_n;
            step_q     <= step_n;
            last_q     <= last_n;
            ill_q      <= ill_n;
            ready_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_n = state_q;
        opc_n   = accept ? Opcode : opc_q;
        valid_n = valid_q;
        op_n    = op_q;
        step_n  = step_q;
        last_n  = last_q;
        ill_n   = ill_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_n = S0;
                    valid_n = 1'b1;
                    op_n    = OPW'(dec_in[4:0]);
                    step_n  = 1'b0;
                    last_n  = dec_in[5];
                    ill_n   = dec_in[6];
                end
            end
            S0, S1: begin
                if (hs && !last_q) begin
                    state_n = S1;
                    op_n    = OPW'(dec_s1[4:0]);
                    step_n  = 1'b1;
                    last_n  = 1'b1;
                    ill_n   = 1'b0;
                end else if (hs && accept) begin
                    state_n = S0;
                    valid_n = 1'b1;
                    op_n    = OPW'(dec_in[4:0]);
                    step_n  = 1'b0;
                    last_n  = dec_in[5];
                    ill_n   = dec_in[6];
                end else if (hs) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    op_n    = '0;
                    step_n  = 1'b0;
                    last_n  = 1'b0;
                    ill_n   = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                op_n    = '0;
                step_n  = 1'b0;
                last_n  = 1'b0;
                ill_n   = 1'b0;
            end
        endcase
        // Flush wins over any handshake or accept in the same cycle.
        if (Flush) begin
            state_n = IDLE;
            valid_n = 1'b0;
            op_n    = '0;
            step_n  = 1'b0;
            last_n  = 1'b0;
            ill_n   = 1'b0;
        end
    end

    assign OutValid  = valid_q;
    assign Operation = op_q;
    assign Step      = step_q;
    assign Last      = last_q;
    assign IllegalOp = ill_q;
    assign dbg_state = state_q;

`ifdef ALUSEQ_PERF_EN
    logic [CNT_W-1:0] instr_q;
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            instr_q <= '0;
            stall_q <= '0;
        end else begin
            if (hs && last_q && (instr_q != '1)) instr_q <= instr_q + 1'b1;
            if (valid_q && !OutReady && (stall_q != '1)) stall_q <= stall_q + 1'b1;
        end
    end

    assign InstrCnt = instr_q;
    assign StallCnt = stall_q;
`else
    assign InstrCnt = '0;
    assign StallCnt = '0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios then random traffic, checked against a beat-queue model.
// Counter expectations follow ALUSEQ_PERF_EN when it is defined.
module tb_alu_op_sequencer;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Flush = 1'b0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [5:0]  Opcode = '0;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [4:0]  Operation;
    logic        Step;
    logic        Last;
    logic        IllegalOp;
    logic [15:0] InstrCnt;
    logic [15:0] StallCnt;
    logic [1:0]  dbg_state;

    logic [7:0]  exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          up = 1'b0;
    int          instr_m = 0;
    int          stall_m = 0;

    alu_op_sequencer dut (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush), .InValid(InValid), .InReady(InReady),
        .Opcode(Opcode), .OutValid(OutValid), .OutReady(OutReady), .Operation(Operation),
        .Step(Step), .Last(Last), .IllegalOp(IllegalOp), .InstrCnt(InstrCnt),
        .StallCnt(StallCnt), .dbg_state(dbg_state)
    );

    // ---- clock ----
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---- reference model: beats of an instruction as {illegal, last, step, op} ----
    task automatic push_beats(input logic [5:0] opc);
        int v;
        int a;
        int b;
        int n;
        bit ill;
        v = int'(opc);
        n = 1; a = 2; b = 0; ill = 1'b0;
        if (v == 0 || v == 1)         a = 2;
        else if (v >= 16 && v <= 23)  a = v - 16;
        else if (v >= 50 && v <= 55)  a = v - 48;
        else if (v >= 57 && v <= 59)  a = v - 57 + 12;
        else if (v == 60)             a = 16;
        else if (v >= 32 && v <= 35) begin n = 2; a = v - 32 + 8; b = 2; end
        else if (v == 61)            begin n = 2; a = 2; b = 15; end
        else if (v == 62)            begin n = 2; a = 2; b = 17; end
        else if (v == 2)             begin n = 2; a = 18; b = 2; end
        else                          ill = 1'b1;
        if (n == 1) exp_q.push_back({ill, 1'b1, 1'b0, a[4:0]});
        else begin
            exp_q.push_back({1'b0, 1'b0, 1'b0, a[4:0]});
            exp_q.push_back({1'b0, 1'b1, 1'b1, b[4:0]});
        end
    endtask

    // ---- scoreboard: compare this cycle, then advance the model ----
    task automatic score();
        bit mv;
        bit er;
        mv = (exp_q.size() != 0);
        check("out_valid", OutValid, mv);
        if (mv) check("beat", {IllegalOp, Last, Step, Operation}, exp_q[0]);
        else    check("illegal_idle", IllegalOp, 0);
        er = up && (exp_q.size() == 0 || (OutReady && exp_q.size() == 1) || Flush);
        check("in_ready", InReady, er);
`ifdef ALUSEQ_PERF_EN
        check("instr_cnt", InstrCnt, instr_m);
        check("stall_cnt", StallCnt, stall_m);
`else
        check("instr_cnt", InstrCnt, 0);
        check("stall_cnt", StallCnt, 0);
`endif
        if (mv && !OutReady && stall_m < 65535) stall_m++;
        if (mv && OutReady && exp_q.size() == 1 && instr_m < 65535) instr_m++;
        if (Flush) exp_q.delete();
        else begin
            if (mv && OutReady) void'(exp_q.pop_front());
            if (InValid && er) push_beats(Opcode);
        end
    endtask

    // ---- driver tasks ----
    task automatic cycle(input logic inv, input logic [5:0] opc, input logic ordy, input logic fl);
        @(negedge Clk);
        InValid = inv; Opcode = opc; OutReady = ordy; Flush = fl;
        #1;
        score();
    endtask

    task automatic model_clear();
        exp_q.delete();
        instr_m = 0;
        stall_m = 0;
        up = 1'b0;
    endtask

    task automatic do_reset();
        Rst_n = 1'b0; Flush = 1'b1; InValid = 1'b1; OutReady = 1'b1; Opcode = 6'b010010;
        model_clear();
        repeat (2) @(negedge Clk);
        #1;
        check("rst_valid", OutValid, 0);
        check("rst_ready", InReady, 0);
        check("rst_fields", {Operation, Step, Last, IllegalOp}, 0);
        check("rst_cnts", {InstrCnt, StallCnt}, 0);
        check("rst_state", dbg_state, 0);
        @(negedge Clk);
        Rst_n = 1'b1; Flush = 1'b0; InValid = 1'b0;
        #1;
        check("ready_before_clk", InReady, 0);
        up = 1'b1;
    endtask

    initial begin
        // 1: single-step opcode, one cycle latency
        do_reset();
        cycle(1, 6'b010010, 1, 0);
        cycle(0, 6'b000000, 1, 0);
        cycle(0, 6'b000000, 1, 0);
        // 2: BEQ, two beats, InReady low between
        cycle(1, 6'b100000, 1, 0);
        cycle(0, 6'b000000, 1, 0);
        check("beq_s1_state", dbg_state, 1);
        cycle(0, 6'b000000, 1, 0);
        check("beq_s2_state", dbg_state, 2);
        cycle(0, 6'b000000, 1, 0);
        // 3: SW held for 3 stall cycles
        do_reset();
        cycle(1, 6'b111110, 0, 0);
        repeat (3) cycle(0, 6'b000000, 0, 0);
        cycle(0, 6'b000000, 1, 0);
`ifdef ALUSEQ_PERF_EN
        check("sw_stall3", StallCnt, 3);
`endif
        cycle(0, 6'b000000, 1, 0);
        // 4: back-to-back ADD, SUB, OR
        do_reset();
        cycle(1, 6'b010010, 1, 0);
        cycle(1, 6'b010011, 1, 0);
        cycle(1, 6'b010100, 1, 0);
        cycle(0, 6'b000000, 1, 0);
        cycle(0, 6'b000000, 1, 0);
`ifdef ALUSEQ_PERF_EN
        check("stream_instr3", InstrCnt, 3);
`endif
        // 5: illegal opcode, then LW flushed in its second beat
        cycle(1, 6'b101111, 1, 0);
        cycle(1, 6'b111101, 1, 0);
        cycle(0, 6'b000000, 1, 0);
        cycle(1, 6'b010001, 0, 1);
        cycle(0, 6'b000000, 1, 0);
        check("flush_state", dbg_state, 0);
        // 6: asynchronous reset in the middle of JAL
        cycle(1, 6'b000010, 1, 0);
        cycle(0, 6'b000000, 1, 0);
        @(negedge Clk);
        InValid = 1'b0; OutReady = 1'b0;
        #1;
        check("jal_s1_valid", {OutValid, Step, Operation}, {1'b1, 1'b1, 5'b00010});
        #1 Rst_n = 1'b0;
        #1;
        check("async_valid", OutValid, 0);
        check("async_fields", {Operation, Step, Last, IllegalOp, InReady}, 0);
        check("async_state", dbg_state, 0);
        model_clear();
        @(negedge Clk);
        Rst_n = 1'b1;
        #1 up = 1'b1;
        cycle(0, 6'b000000, 1, 0);
        check("post_rst_cnts", {InstrCnt, StallCnt}, 0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic inv;
            logic fl;
            logic ordy;
            logic [5:0] opc;
            inv  = ($urandom_range(0, 3) != 0);
            opc  = 6'($urandom_range(0, 63));
            fl   = ($urandom_range(0, 19) == 0);
            ordy = fl ? 1'b0 : ($urandom_range(0, 3) != 0);
            cycle(inv, opc, ordy, fl);
        end
        repeat (3) cycle(0, 6'b000000, 1, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
